// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the arbitrated register bank.
// Requester encoding doubles as the round-robin pointer value.
package reg_bank_pkg;

  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 4;
  localparam int NUM_REGS = 4;
  localparam int CNT_W    = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } requester_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
// The pointer records the last granted requester; a tie goes to the other.
module rr_arbiter_2
  import reg_bank_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_last
);

  requester_t last_q;
  requester_t last_d;

  // Grant decode; nothing is granted while reset is held.
  always_comb begin
    o_gnt  = 2'b00;
    last_d = last_q;
    if (!i_rst) begin
      if (i_req[0] && (!i_req[1] || last_q == REQ_B)) begin
        o_gnt  = 2'b01;
        last_d = REQ_A;
      end else if (i_req[1]) begin
        o_gnt  = 2'b10;
        last_d = REQ_B;
      end
    end
  end

  // Pointer flop; resets to B so A wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

  assign o_last = (last_q == REQ_B);

endmodule

// File: rtl/reg_bank_arbiter.sv
// Four-entry register bank shared by two write requesters.
// Writes land one edge after the handshake; reads are a plain mux.
module reg_bank_arbiter
  import reg_bank_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_valid,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [CNT_W-1:0]  o_wr_count,
  output logic              o_last_grant
);

  logic [1:0]        gnt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;

  rr_arbiter_2 u_arb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  ({i_b_valid, i_a_valid}),
    .o_gnt  (gnt),
    .o_last (o_last_grant)
  );

  assign o_a_ready = gnt[0];
  assign o_b_ready = gnt[1];
  assign wr_en     = |gnt;
  assign wr_addr   = gnt[1] ? i_b_addr : i_a_addr;
  assign wr_data   = gnt[1] ? i_b_data : i_a_data;

  // Bank storage: only the granted address is updated.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Completed-write counter, saturating at all ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (wr_en && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_rd_data  = regs[i_rd_addr];
  assign o_wr_count = cnt_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed and randomized bench for reg_bank_arbiter.
// Reference model keeps the bank as an array plus a last-winner flag.
module tb_reg_bank_arbiter;

  logic       clk;
  logic       rst;
  logic       a_valid;
  logic [1:0] a_addr;
  logic [3:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [1:0] b_addr;
  logic [3:0] b_data;
  logic       b_ready;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic [7:0] wr_count;
  logic       last_grant;

  int n_chk  = 0;
  int n_fail = 0;

  int m_bank [4];
  int m_cnt;
  int m_last;
  int wait_a;
  int wait_b;

  reg_bank_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_a_valid    (a_valid),
    .i_a_addr     (a_addr),
    .i_a_data     (a_data),
    .o_a_ready    (a_ready),
    .i_b_valid    (b_valid),
    .i_b_addr     (b_addr),
    .i_b_data     (b_data),
    .o_b_ready    (b_ready),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_wr_count   (wr_count),
    .o_last_grant (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = 0;
    m_cnt  = 0;
    m_last = 1;
    wait_a = 0;
    wait_b = 0;
  endtask

  // Hold reset for two edges with both requesters asking.
  task automatic do_reset();
    a_valid = 1'b1;
    b_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_a_ready", {7'd0, a_ready}, 8'd0);
    chk("rst_b_ready", {7'd0, b_ready}, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_count", wr_count, 8'd0);
    chk("rst_last", {7'd0, last_grant}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk("rst_reg", {4'd0, rd_data}, 8'd0);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle of stimulus, checked before and after the edge.
  task automatic step(input bit av, input int aa, input int ad,
                      input bit bv, input int ba, input int bd,
                      input int ra);
    bit ga;
    bit gb;
    a_valid = av;
    a_addr  = 2'(aa);
    a_data  = 4'(ad);
    b_valid = bv;
    b_addr  = 2'(ba);
    b_data  = 4'(bd);
    rd_addr = 2'(ra);
    ga = av && (!bv || m_last == 1);
    gb = bv && !ga;
    #1;
    chk("a_ready", {7'd0, a_ready}, {7'd0, ga});
    chk("b_ready", {7'd0, b_ready}, {7'd0, gb});
    chk("one_hot", {7'd0, a_ready & b_ready}, 8'd0);
    chk("rd_pre", {4'd0, rd_data}, 8'(m_bank[ra]));
    if (a_ready || !av) wait_a = 0; else wait_a++;
    if (b_ready || !bv) wait_b = 0; else wait_b++;
    chk("starve_a", {7'd0, wait_a < 2}, 8'd1);
    chk("starve_b", {7'd0, wait_b < 2}, 8'd1);
    @(posedge clk);
    if (ga) begin
      m_bank[aa] = ad;
      m_last = 0;
    end
    if (gb) begin
      m_bank[ba] = bd;
      m_last = 1;
    end
    if ((ga || gb) && m_cnt < 255) m_cnt++;
    #1;
    chk("rd_post", {4'd0, rd_data}, 8'(m_bank[ra]));
    chk("count", wr_count, 8'(m_cnt));
    chk("last", {7'd0, last_grant}, 8'(m_last));
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    rd_addr = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single write from A, then read it back.
    step(1, 2, 4'hA, 0, 0, 0, 2);
    chk("a_write_val", {4'd0, rd_data}, 8'h0A);
    chk("a_write_cnt", wr_count, 8'd1);

    // Tie after reset: A first, then B.
    do_reset();
    step(1, 0, 4'h3, 1, 1, 4'h5, 0);
    chk("tie_first", {7'd0, last_grant}, 8'd0);
    step(1, 0, 4'h3, 1, 1, 4'h5, 1);
    chk("tie_second", {7'd0, last_grant}, 8'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("tie_reg0", {4'd0, rd_data}, 8'h03);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("tie_reg1", {4'd0, rd_data}, 8'h05);

    // Same-address collision; the second winner lands last.
    step(1, 3, 4'h1, 1, 3, 4'hF, 3);
    step(1, 3, 4'h1, 1, 3, 4'hF, 3);
    chk("same_addr", {4'd0, rd_data}, 8'h0F);

    // Saturation of the write counter.
    for (int i = 0; i < 300; i++) begin
      step(1, i % 4, i % 16, 0, 0, 0, (i + 1) % 4);
    end
    chk("sat_count", wr_count, 8'd255);

    // Reset lands in the middle of an A handshake.
    a_valid = 1; a_addr = 1; a_data = 4'h7;
    b_valid = 0;
    #1;
    chk("mid_a_ready", {7'd0, a_ready}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_a_rdy0", {7'd0, a_ready}, 8'd0);
    chk("mid_b_rdy0", {7'd0, b_ready}, 8'd0);
    chk("mid_count", wr_count, 8'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk("mid_reg", {4'd0, rd_data}, 8'd0);
    end
    chk("mid_count2", wr_count, 8'd0);
    chk("mid_rdy_held", {6'd0, a_ready, b_ready}, 8'd0);
    a_valid = 0;
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3),
           $urandom_range(0, 15),
           1'($urandom_range(0, 1)), $urandom_range(0, 3),
           $urandom_range(0, 15),
           $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
